// File: rtl/mem_lsu_be_pkg.sv
// Shared MEM-stage types: access width codes, write-back source select, EXE/MEM and MEM/WB payloads.
// No logic, so no latency.
// No flow control here; the payloads carry no handshake.
package mem_lsu_be_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        WB_SRC_ALU    = 2'd0,
        WB_SRC_MEM    = 2'd1,
        WB_SRC_PC_INC = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic       mem_load;
        logic       mem_store;
        logic       register_write;
        wb_src_e    result_src;
        logic [2:0] mem_width;
    } exe_ctrl_t;

    typedef struct packed {
        exe_ctrl_t   ctrl;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_inc;
        logic [4:0]  rd;
    } exe_mem_inf_t;

    typedef struct packed {
        logic    mem_load;
        logic    register_write;
        wb_src_e result_src;
    } wb_ctrl_t;

    typedef struct packed {
        wb_ctrl_t    ctrl;
        logic [31:0] read_data;
        logic [31:0] alu_result_or_pc_inc;
        logic [4:0]  rd;
    } mem_wb_inf_t;

endpackage

// File: rtl/mem_lsu_be_bram.sv
// Byte-enabled 1R1W block RAM; read returns the old word on a same-address write.
// Latency: one cycle, synchronous read.
// No backpressure: one read and one write are accepted every cycle.
module bram_1r1w_be #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_BYTES  = 4
) (
    input  logic                   clk,
    input  logic [NUM_BYTES-1:0]   we,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [8*NUM_BYTES-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [8*NUM_BYTES-1:0] rdata
);

    logic [8*NUM_BYTES-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_lsu_be.sv
// Load/store unit for the MEM stage: lane steering, sign-extension, fault checks, store-to-load forwarding.
// Latency: one cycle; the request in cycle N produces its MEM/WB beat in cycle N+1.
// No backpressure: one access per cycle, no stall output.
module mem_lsu_be
    import mem_lsu_be_pkg::*;
#(
    parameter int MEM_BYTES = 16384,
    parameter int XLEN      = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  exe_mem_inf_t exe_mem_inf,
    output mem_wb_inf_t  mem_wb_inf,
    output logic         mem_fault
);

    localparam int NB = XLEN / 8;
    localparam int AB = $clog2(MEM_BYTES);
    localparam int AW = (AB > 2) ? AB - 2 : 1;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    logic [1:0]      off;
    logic [2:0]      width;
    logic [AW-1:0]   word_idx;
    logic            is_store, is_load, misalign, fault, fwd_hit;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata_rep;

    wb_ctrl_t        wb_ctrl_q;
    logic            fault_q, load_q, fwd_vld;
    logic [2:0]      width_q;
    logic [1:0]      off_q;
    logic [NB-1:0]   fwd_be, wr_be_q;
    logic [XLEN-1:0] fwd_data, wr_data_q, rdata, merged, load_val;
    logic [AW-1:0]   wr_addr_q;
    logic [31:0]     res_q;
    logic [4:0]      rd_q;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    assign off      = exe_mem_inf.alu_result[1:0];
    assign width    = exe_mem_inf.ctrl.mem_width;
    assign word_idx = exe_mem_inf.alu_result[AW+1:2];
    assign is_store = exe_mem_inf.ctrl.mem_store;
    assign is_load  = exe_mem_inf.ctrl.mem_load & ~is_store;

    // Width codes outside the legal set for the access direction count as misaligned.
    always_comb begin
        misalign = 1'b1;
        if (is_store) begin
            case (width)
                MEM_B:   misalign = 1'b0;
                MEM_H:   misalign = off[0];
                MEM_W:   misalign = |off;
                default: misalign = 1'b1;
            endcase
        end else begin
            case (width)
                MEM_B, MEM_BU: misalign = 1'b0;
                MEM_H, MEM_HU: misalign = off[0];
                MEM_W:         misalign = |off;
                default:       misalign = 1'b1;
            endcase
        end
    end

    assign fault   = (is_store | is_load) & (misalign | (exe_mem_inf.alu_result >= MEM_LIMIT));
    assign fwd_hit = is_load & (|wr_be_q) & (wr_addr_q == word_idx);

    always_comb begin
        be        = '0;
        wdata_rep = exe_mem_inf.write_data;
        case (width)
            MEM_B: begin
                be        = NB'(1) << off;
                wdata_rep = {NB{exe_mem_inf.write_data[7:0]}};
            end
            MEM_H: begin
                be        = NB'(3) << off;
                wdata_rep = {(NB/2){exe_mem_inf.write_data[15:0]}};
            end
            MEM_W:   be = '1;
            default: be = '0;
        endcase
        if (!is_store || fault) begin
            be = '0;
        end
    end

    // Stores are written one cycle after acceptance, so a load right behind a store
    // reads the stale word and must merge the pending bytes.
    bram_1r1w_be #(
        .ADDR_WIDTH (AW),
        .NUM_BYTES  (NB)
    ) u_bram (
        .clk   (clk),
        .we    (wr_be_q),
        .waddr (wr_addr_q),
        .wdata (wr_data_q),
        .raddr (word_idx),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ctrl_q <= '0;
            fault_q   <= 1'b0;
            load_q    <= 1'b0;
            width_q   <= '0;
            off_q     <= '0;
            fwd_vld   <= 1'b0;
            fwd_be    <= '0;
            fwd_data  <= '0;
            wr_be_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            res_q     <= '0;
            rd_q      <= '0;
        end else begin
            wb_ctrl_q.mem_load       <= is_load;
            wb_ctrl_q.register_write <= exe_mem_inf.ctrl.register_write & ~(is_load & fault);
            wb_ctrl_q.result_src     <= exe_mem_inf.ctrl.result_src;
            fault_q   <= fault;
            load_q    <= is_load & ~fault;
            width_q   <= width;
            off_q     <= off;
            fwd_vld   <= fwd_hit;
            fwd_be    <= wr_be_q;
            fwd_data  <= wr_data_q;
            wr_be_q   <= be;
            wr_addr_q <= word_idx;
            wr_data_q <= wdata_rep;
            res_q     <= (exe_mem_inf.ctrl.result_src == WB_SRC_PC_INC) ?
                         exe_mem_inf.pc_inc : exe_mem_inf.alu_result;
            rd_q      <= exe_mem_inf.rd;
        end
    end

    always_comb begin
        merged = rdata;
        for (int i = 0; i < NB; i++) begin
            if (fwd_vld && fwd_be[i]) begin
                merged[8*i +: 8] = fwd_data[8*i +: 8];
            end
        end
        lane_b = merged[{off_q, 3'b000} +: 8];
        lane_h = merged[{off_q[1], 4'b0000} +: 16];
        case (width_q)
            MEM_B:   load_val = {{(XLEN-8){lane_b[7]}}, lane_b};
            MEM_BU:  load_val = {{(XLEN-8){1'b0}}, lane_b};
            MEM_H:   load_val = {{(XLEN-16){lane_h[15]}}, lane_h};
            MEM_HU:  load_val = {{(XLEN-16){1'b0}}, lane_h};
            MEM_W:   load_val = merged;
            default: load_val = '0;
        endcase
        if (!load_q) begin
            load_val = '0;
        end
    end

    always_comb begin
        mem_wb_inf                      = '0;
        mem_wb_inf.ctrl                 = wb_ctrl_q;
        mem_wb_inf.read_data            = load_val;
        mem_wb_inf.alu_result_or_pc_inc = res_q;
        mem_wb_inf.rd                   = rd_q;
    end

    assign mem_fault = fault_q;

endmodule

// File: tb/tb_mem_lsu_be.sv
// Self-checking bench for mem_lsu_be: directed corner cases plus random traffic against a byte-array model.
module tb_mem_lsu_be;
    import mem_lsu_be_pkg::*;

    localparam int MEM_BYTES = 16384;

    logic         clk;
    logic         rst;
    exe_mem_inf_t op;
    mem_wb_inf_t  wb;
    logic         fault;
    int           total;
    int           bad;
    logic [7:0]   mm [MEM_BYTES];

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
        logic        rw;
        logic        mload;
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    mem_lsu_be #(.MEM_BYTES(MEM_BYTES), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .exe_mem_inf (op),
        .mem_wb_inf  (wb),
        .mem_fault   (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exe_mem_inf_t mk(input logic ld, input logic st, input logic [2:0] w,
                                        input logic [31:0] a, input logic [31:0] wd);
        exe_mem_inf_t o;
        o = '0;
        o.ctrl.mem_load       = ld;
        o.ctrl.mem_store      = st;
        o.ctrl.register_write = ld;
        o.ctrl.result_src     = ld ? WB_SRC_MEM : WB_SRC_ALU;
        o.ctrl.mem_width      = w;
        o.alu_result          = a;
        o.write_data          = wd;
        o.pc_inc              = a + 32'd4;
        o.rd                  = 5'd7;
        return o;
    endfunction

    // Reference: memory as a byte array, accesses as byte sequences starting at the address.
    function automatic exp_t model(input exe_mem_inf_t o);
        exp_t        e;
        int          size;
        logic        ld, st, sgn, flt;
        logic [31:0] a, v;
        ld   = o.ctrl.mem_load && !o.ctrl.mem_store;
        st   = o.ctrl.mem_store;
        a    = o.alu_result;
        size = 0;
        sgn  = 1'b0;
        if (st) begin
            case (o.ctrl.mem_width)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: size = 0;
            endcase
        end else if (ld) begin
            case (o.ctrl.mem_width)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: size = 0;
            endcase
        end
        flt = 1'b0;
        if (ld || st) begin
            if (size == 0) flt = 1'b1;
            else if ((a % size) != 0) flt = 1'b1;
            else if (a >= MEM_BYTES) flt = 1'b1;
        end
        v = '0;
        if (st && !flt) begin
            for (int i = 0; i < size; i++) mm[a + i] = o.write_data[8*i +: 8];
        end
        if (ld && !flt) begin
            for (int i = 0; i < size; i++) v = v | (32'(mm[a + i]) << (8*i));
            if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        end
        e.fault = flt;
        e.rdata = v;
        e.rw    = o.ctrl.register_write && !(ld && flt);
        e.mload = ld;
        e.res   = (o.ctrl.result_src == WB_SRC_PC_INC) ? o.pc_inc : a;
        e.rd    = o.rd;
        return e;
    endfunction

    task automatic issue(input exe_mem_inf_t o);
        op = o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        op  = mk(1'b1, 1'b0, MEM_W, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        total++; if (wb.ctrl.register_write !== 1'b0) begin bad++; $display("FAIL reset_rw got=%b exp=0", wb.ctrl.register_write); end
        total++; if (wb.ctrl.mem_load !== 1'b0) begin bad++; $display("FAIL reset_mload got=%b exp=0", wb.ctrl.mem_load); end
        total++; if (wb.ctrl.result_src !== WB_SRC_ALU) begin bad++; $display("FAIL reset_src got=%0d exp=0", wb.ctrl.result_src); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        total++; if (wb.read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", wb.read_data); end
        op  = '0;
        rst = 1'b1;
        issue('0);
        total++; if (wb.ctrl.register_write !== 1'b0) begin bad++; $display("FAIL post_reset_rw got=%b exp=0", wb.ctrl.register_write); end
    endtask

    task automatic init_mem();
        exe_mem_inf_t o;
        exp_t         e;
        for (int i = 0; i < 64; i++) begin
            o = mk(1'b0, 1'b1, MEM_W, 32'(i * 4), $urandom);
            e = model(o);
            issue(o);
            total++; if (fault !== e.fault) begin bad++; $display("FAIL init_fault i=%0d got=%b exp=%b", i, fault, e.fault); end
        end
    endtask

    task automatic test_directed();
        exe_mem_inf_t o;
        exp_t         e;
        o = mk(1'b0, 1'b1, MEM_W, 32'h10, 32'hDEADBEEF); e = model(o); issue(o);
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL sw_10_fault got=%b exp=0", fault); end
        o = mk(1'b1, 1'b0, MEM_B, 32'h13, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data !== 32'hFFFFFFDE) begin bad++; $display("FAIL lb_13 got=%h exp=ffffffde", wb.read_data); end
        o = mk(1'b1, 1'b0, MEM_BU, 32'h13, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data !== 32'h000000DE) begin bad++; $display("FAIL lbu_13 got=%h exp=000000de", wb.read_data); end
        o = mk(1'b0, 1'b1, MEM_H, 32'h22, 32'h00001234); e = model(o); issue(o);
        o = mk(1'b1, 1'b0, MEM_W, 32'h20, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data[31:16] !== 16'h1234) begin bad++; $display("FAIL lw_20_upper got=%h exp=1234", wb.read_data[31:16]); end
        total++; if (wb.read_data !== e.rdata) begin bad++; $display("FAIL lw_20 got=%h exp=%h", wb.read_data, e.rdata); end
        o = mk(1'b1, 1'b0, MEM_H, 32'h21, 32'h0); e = model(o); issue(o);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL lh_21_fault got=%b exp=1", fault); end
        total++; if (wb.ctrl.register_write !== 1'b0) begin bad++; $display("FAIL lh_21_rw got=%b exp=0", wb.ctrl.register_write); end
        total++; if (wb.read_data !== 32'h0) begin bad++; $display("FAIL lh_21_rdata got=%h exp=0", wb.read_data); end
        o = mk(1'b0, 1'b1, MEM_W, 32'h02, 32'hCAFEF00D); e = model(o); issue(o);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL sw_02_fault got=%b exp=1", fault); end
        o = mk(1'b1, 1'b0, MEM_W, 32'h00, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data !== e.rdata) begin bad++; $display("FAIL sw_02_unchanged got=%h exp=%h", wb.read_data, e.rdata); end
        o = mk(1'b0, 1'b1, MEM_B, 32'h40, 32'h000000AA); e = model(o); issue(o);
        o = mk(1'b1, 1'b0, MEM_W, 32'h40, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data[7:0] !== 8'hAA) begin bad++; $display("FAIL fwd_40_byte0 got=%h exp=aa", wb.read_data[7:0]); end
        total++; if (wb.read_data !== e.rdata) begin bad++; $display("FAIL fwd_40 got=%h exp=%h", wb.read_data, e.rdata); end
        o = mk(1'b0, 1'b1, MEM_W, 32'h4000, 32'h13579BDF); e = model(o); issue(o);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL oor_fault got=%b exp=1", fault); end
        o = mk(1'b1, 1'b0, MEM_W, 32'h00, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data !== e.rdata) begin bad++; $display("FAIL oor_no_write got=%h exp=%h", wb.read_data, e.rdata); end
        o = mk(1'b0, 1'b0, MEM_B, 32'h55, 32'h0);
        o.ctrl.result_src = WB_SRC_PC_INC; o.ctrl.register_write = 1'b1; o.pc_inc = 32'h104;
        e = model(o); issue(o);
        total++; if (wb.alu_result_or_pc_inc !== 32'h104) begin bad++; $display("FAIL pc_inc got=%h exp=00000104", wb.alu_result_or_pc_inc); end
        o.ctrl.result_src = WB_SRC_ALU; e = model(o); issue(o);
        total++; if (wb.alu_result_or_pc_inc !== 32'h55) begin bad++; $display("FAIL alu_sel got=%h exp=00000055", wb.alu_result_or_pc_inc); end
        o = mk(1'b1, 1'b1, MEM_W, 32'h44, 32'h11223344); e = model(o); issue(o);
        total++; if (wb.ctrl.mem_load !== 1'b0) begin bad++; $display("FAIL ldst_mload got=%b exp=0", wb.ctrl.mem_load); end
        o = mk(1'b1, 1'b0, MEM_W, 32'h44, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data !== 32'h11223344) begin bad++; $display("FAIL ldst_store_wins got=%h exp=11223344", wb.read_data); end
        o = mk(1'b1, 1'b0, 3'b011, 32'h00, 32'h0); e = model(o); issue(o);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL bad_width_load got=%b exp=1", fault); end
        o = mk(1'b0, 1'b1, MEM_BU, 32'h48, 32'hFFFFFFFF); e = model(o); issue(o);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL bad_width_store got=%b exp=1", fault); end
        o = mk(1'b1, 1'b0, MEM_W, 32'h48, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data !== e.rdata) begin bad++; $display("FAIL bad_width_no_write got=%h exp=%h", wb.read_data, e.rdata); end
    endtask

    task automatic test_forwarding();
        exe_mem_inf_t o;
        exp_t         e;
        logic [2:0]   w;
        logic [31:0]  base, a;
        for (int i = 0; i < 48; i++) begin
            base = 32'($urandom_range(0, 15)) * 32'd4;
            w    = 3'($urandom_range(0, 2));
            a    = base + ((w == MEM_W) ? 32'd0 : (w == MEM_H) ? 32'($urandom_range(0, 1)) * 2 : 32'($urandom_range(0, 3)));
            o = mk(1'b0, 1'b1, w, a, $urandom); e = model(o); issue(o);
            total++; if (fault !== e.fault) begin bad++; $display("FAIL fwd_st_fault i=%0d got=%b exp=%b", i, fault, e.fault); end
            case ($urandom_range(0, 4))
                0: w = MEM_B;
                1: w = MEM_BU;
                2: w = MEM_H;
                3: w = MEM_HU;
                default: w = MEM_W;
            endcase
            a = base + ((w == MEM_W) ? 32'd0 : (w == MEM_H || w == MEM_HU) ? 32'($urandom_range(0, 1)) * 2 : 32'($urandom_range(0, 3)));
            o = mk(1'b1, 1'b0, w, a, 32'h0); e = model(o); issue(o);
            total++; if (wb.read_data !== e.rdata) begin bad++; $display("FAIL fwd_ld i=%0d a=%h w=%0d got=%h exp=%h", i, a, w, wb.read_data, e.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        exe_mem_inf_t o;
        exp_t         e;
        logic [31:0]  a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 15) == 0) ? 32'(MEM_BYTES + $urandom_range(0, 255)) : 32'($urandom_range(0, 255));
            o = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), a, $urandom);
            o.ctrl.register_write = 1'($urandom_range(0, 1));
            o.ctrl.result_src     = wb_src_e'($urandom_range(0, 2));
            o.pc_inc              = $urandom;
            o.rd                  = 5'($urandom);
            e = model(o);
            issue(o);
            total++; if (fault !== e.fault) begin bad++; $display("FAIL b2b_fault i=%0d got=%b exp=%b", i, fault, e.fault); end
            total++; if (wb.read_data !== e.rdata) begin bad++; $display("FAIL b2b_rdata i=%0d got=%h exp=%h", i, wb.read_data, e.rdata); end
            total++; if (wb.ctrl.register_write !== e.rw) begin bad++; $display("FAIL b2b_rw i=%0d got=%b exp=%b", i, wb.ctrl.register_write, e.rw); end
            total++; if (wb.ctrl.mem_load !== e.mload) begin bad++; $display("FAIL b2b_mload i=%0d got=%b exp=%b", i, wb.ctrl.mem_load, e.mload); end
            total++; if (wb.alu_result_or_pc_inc !== e.res) begin bad++; $display("FAIL b2b_res i=%0d got=%h exp=%h", i, wb.alu_result_or_pc_inc, e.res); end
            total++; if (wb.rd !== e.rd) begin bad++; $display("FAIL b2b_rd i=%0d got=%0d exp=%0d", i, wb.rd, e.rd); end
        end
    endtask

    task automatic test_reset_midstream();
        exe_mem_inf_t o;
        exp_t         e;
        o = mk(1'b1, 1'b0, MEM_W, 32'h0, 32'h0); e = model(o); issue(o);
        total++; if (wb.ctrl.register_write !== 1'b1) begin bad++; $display("FAIL pre_rst_rw got=%b exp=1", wb.ctrl.register_write); end
        rst = 1'b0;
        #1;
        total++; if (wb.ctrl.register_write !== 1'b0) begin bad++; $display("FAIL rst_async_rw got=%b exp=0", wb.ctrl.register_write); end
        total++; if (wb.ctrl.mem_load !== 1'b0) begin bad++; $display("FAIL rst_async_mload got=%b exp=0", wb.ctrl.mem_load); end
        total++; if (wb.ctrl.result_src !== WB_SRC_ALU) begin bad++; $display("FAIL rst_async_src got=%0d exp=0", wb.ctrl.result_src); end
        op = mk(1'b0, 1'b1, MEM_W, 32'h80, ~{mm[8'h83], mm[8'h82], mm[8'h81], mm[8'h80]});
        repeat (2) @(posedge clk);
        #1;
        op  = '0;
        rst = 1'b1;
        issue('0);
        total++; if (wb.ctrl.register_write !== 1'b0) begin bad++; $display("FAIL rst_release_rw got=%b exp=0", wb.ctrl.register_write); end
        o = mk(1'b1, 1'b0, MEM_W, 32'h80, 32'h0); e = model(o); issue(o);
        total++; if (wb.read_data !== e.rdata) begin bad++; $display("FAIL rst_no_write got=%h exp=%h", wb.read_data, e.rdata); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        op    = '0;
        test_reset();
        init_mem();
        test_directed();
        test_forwarding();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
